// File: rtl/pwm_cfg_pkg.sv
// Shared constants for the PWM configuration bank: register map, reset values
// and the round-robin pointer encoding.
package pwm_cfg_pkg;

  localparam int unsigned REG_EN_OUT_LO = 0;
  localparam int unsigned REG_EN_OUT_HI = 1;
  localparam int unsigned REG_EN_PWM_LO = 2;
  localparam int unsigned REG_EN_PWM_HI = 3;
  localparam int unsigned REG_DUTY      = 4;
  localparam int unsigned REG_FADE_TGT  = 5;
  localparam int unsigned REG_FADE_CTRL = 6;

  localparam logic [7:0] RST_REG_VAL  = 8'h00;
  localparam logic       RST_FADE_EN  = 1'b0;
  localparam int unsigned FADE_EN_BIT = 0;

  typedef enum logic {
    RR_A = 1'b0,
    RR_B = 1'b1
  } rr_e;

endpackage

// File: rtl/pwm_fade_seq.sv
// Fade prescaler and step decision: on each prescaler wrap, requests one step
// of the duty register toward the target.
module pwm_fade_seq
  import pwm_cfg_pkg::*;
#(
  parameter int unsigned FADE_DIV = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] duty_i,
  input  logic [7:0] target_i,
  input  logic       en_i,
  output logic       step_up_o,
  output logic       step_dn_o,
  output logic       busy_o
);

  localparam int unsigned CNT_W = (FADE_DIV > 2) ? $clog2(FADE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FADE_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             wrap_s;

  // Prescaler next state and step decision; counter held at zero while disabled.
  always_comb begin
    wrap_s    = en_i && (cnt_q == CNT_MAX);
    cnt_d     = cnt_q;
    step_up_o = 1'b0;
    step_dn_o = 1'b0;
    if (!en_i) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (wrap_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (wrap_s && (duty_i < target_i)) begin
      step_up_o = 1'b1;
    end else if (wrap_s && (duty_i > target_i)) begin
      step_dn_o = 1'b1;
    end else begin
      step_up_o = 1'b0;
      step_dn_o = 1'b0;
    end
    busy_o = en_i && (duty_i != target_i);
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_cfg_arbiter.sv
// PWM configuration register bank with a round-robin write arbiter between the
// SPI port (A) and the host port (B), plus a lowest-priority fade sequencer.
module pwm_cfg_arbiter
  import pwm_cfg_pkg::*;
#(
  parameter int unsigned FADE_DIV = 1024,
  parameter int unsigned ADDR_W   = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [7:0]        a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [7:0]        b_data,
  output logic              b_ready,
  output logic [7:0]        en_reg_out_7_0,
  output logic [7:0]        en_reg_out_15_8,
  output logic [7:0]        en_reg_pwm_7_0,
  output logic [7:0]        en_reg_pwm_15_8,
  output logic [7:0]        pwm_duty_cycle,
  output logic              fade_busy,
  output logic              addr_err
);

  rr_e         rr_q, rr_d;
  logic        grant_a_s, grant_b_s, wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [7:0]  wr_data_s;
  logic        step_up_s, step_dn_s, duty_wr_s;

  logic [7:0]  out_lo_q, out_lo_d, out_hi_q, out_hi_d;
  logic [7:0]  pwm_lo_q, pwm_lo_d, pwm_hi_q, pwm_hi_d;
  logic [7:0]  duty_q, duty_d, target_q, target_d;
  logic        fade_en_q, fade_en_d, addr_err_q, addr_err_d;

  // Round-robin grant; the pointer only moves when both ports contend.
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    rr_d      = rr_q;
    if (reset) begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end else if (a_valid && b_valid) begin
      grant_a_s = (rr_q == RR_A);
      grant_b_s = (rr_q == RR_B);
      rr_d      = (rr_q == RR_A) ? RR_B : RR_A;
    end else begin
      grant_a_s = a_valid;
      grant_b_s = b_valid;
    end
    wr_en_s   = grant_a_s || grant_b_s;
    wr_addr_s = grant_a_s ? a_addr : b_addr;
    wr_data_s = grant_a_s ? a_data : b_data;
  end

  assign a_ready = grant_a_s;
  assign b_ready = grant_b_s;

  pwm_fade_seq #(
    .FADE_DIV (FADE_DIV)
  ) u_fade (
    .clk       (clk),
    .reset     (reset),
    .duty_i    (duty_q),
    .target_i  (target_q),
    .en_i      (fade_en_q),
    .step_up_o (step_up_s),
    .step_dn_o (step_dn_s),
    .busy_o    (fade_busy)
  );

  // Register bank next state; an external duty write overrides a coincident fade step.
  always_comb begin
    out_lo_d   = out_lo_q;
    out_hi_d   = out_hi_q;
    pwm_lo_d   = pwm_lo_q;
    pwm_hi_d   = pwm_hi_q;
    duty_d     = duty_q;
    target_d   = target_q;
    fade_en_d  = fade_en_q;
    addr_err_d = 1'b0;
    duty_wr_s  = 1'b0;
    if (wr_en_s) begin
      case (wr_addr_s)
        ADDR_W'(REG_EN_OUT_LO): out_lo_d = wr_data_s;
        ADDR_W'(REG_EN_OUT_HI): out_hi_d = wr_data_s;
        ADDR_W'(REG_EN_PWM_LO): pwm_lo_d = wr_data_s;
        ADDR_W'(REG_EN_PWM_HI): pwm_hi_d = wr_data_s;
        ADDR_W'(REG_DUTY): begin
          duty_d    = wr_data_s;
          duty_wr_s = 1'b1;
        end
        ADDR_W'(REG_FADE_TGT):  target_d  = wr_data_s;
        ADDR_W'(REG_FADE_CTRL): fade_en_d = wr_data_s[FADE_EN_BIT];
        default:                addr_err_d = 1'b1;
      endcase
    end else begin
      addr_err_d = 1'b0;
    end
    if (!duty_wr_s && step_up_s) begin
      duty_d = duty_q + 8'd1;
    end else if (!duty_wr_s && step_dn_s) begin
      duty_d = duty_q - 8'd1;
    end else begin
      duty_wr_s = duty_wr_s;
    end
  end

  // Bank, fade control and arbiter pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q       <= RR_A;
      out_lo_q   <= RST_REG_VAL;
      out_hi_q   <= RST_REG_VAL;
      pwm_lo_q   <= RST_REG_VAL;
      pwm_hi_q   <= RST_REG_VAL;
      duty_q     <= RST_REG_VAL;
      target_q   <= RST_REG_VAL;
      fade_en_q  <= RST_FADE_EN;
      addr_err_q <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      out_lo_q   <= out_lo_d;
      out_hi_q   <= out_hi_d;
      pwm_lo_q   <= pwm_lo_d;
      pwm_hi_q   <= pwm_hi_d;
      duty_q     <= duty_d;
      target_q   <= target_d;
      fade_en_q  <= fade_en_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign en_reg_out_7_0  = out_lo_q;
  assign en_reg_out_15_8 = out_hi_q;
  assign en_reg_pwm_7_0  = pwm_lo_q;
  assign en_reg_pwm_15_8 = pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;
  assign addr_err        = addr_err_q;

endmodule

// File: tb/tb_pwm_cfg_arbiter.sv
// Scoreboard bench for pwm_cfg_arbiter: a register-map reference model predicts
// grants and post-edge register state; a monitor compares them cycle by cycle.
module tb_pwm_cfg_arbiter;

  localparam int unsigned FADE_DIV = 4;
  localparam int unsigned ADDR_W   = 7;

  logic              clk = 1'b0;
  logic              reset;
  logic              a_valid, b_valid, a_ready, b_ready;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [7:0]        a_data, b_data;
  logic [7:0]        r0, r1, r2, r3, r4;
  logic              fade_busy, addr_err;

  pwm_cfg_arbiter #(.FADE_DIV(FADE_DIV), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
    .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4),
    .fade_busy(fade_busy), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] o0, o1, o2, o3, o4;
    logic       busy;
    logic       err;
  } obs_t;

  obs_t       exp_state_q[$];
  logic [1:0] exp_rdy_q[$];
  int         checks = 0;
  int         errors = 0;

  // Reference model: register map as an array (index 5 = fade target)
  int unsigned m_reg[6];
  bit          m_en, m_b_turn, m_err;
  int unsigned m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_reg[i] = 0;
    m_en = 0; m_b_turn = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit av, input int unsigned aa, input int unsigned ad,
                            input bit bv, input int unsigned ba, input int unsigned bd,
                            output bit ga, output bit gb);
    bit step, duty_written, new_en;
    int unsigned old_duty, old_tgt, wa, wd;
    ga = av && (!bv || !m_b_turn);
    gb = bv && (!av || m_b_turn);
    if (av && bv) m_b_turn = !m_b_turn;
    step = m_en && ((m_cnt % FADE_DIV) == FADE_DIV - 1);
    old_duty = m_reg[4];
    old_tgt  = m_reg[5];
    new_en = m_en;
    duty_written = 0;
    m_err = 0;
    if (ga || gb) begin
      wa = ga ? aa : ba;
      wd = ga ? ad : bd;
      if (wa <= 5) m_reg[wa] = wd;
      if (wa == 4) duty_written = 1;
      else if (wa == 6) new_en = wd[0];
      else if (wa > 6) m_err = 1;
    end
    m_cnt = m_en ? m_cnt + 1 : 0;
    m_en = new_en;
    if (step && !duty_written) begin
      if (old_duty < old_tgt) m_reg[4] = old_duty + 1;
      else if (old_duty > old_tgt) m_reg[4] = old_duty - 1;
    end
  endtask

  // Drive one cycle of requests and queue the predicted response.
  task automatic cycle(input bit av, input int unsigned aa, input int unsigned ad,
                       input bit bv, input int unsigned ba, input int unsigned bd,
                       output bit ga, output bit gb);
    obs_t e;
    @(posedge clk); #2;
    a_valid = av; a_addr = ADDR_W'(aa); a_data = 8'(ad);
    b_valid = bv; b_addr = ADDR_W'(ba); b_data = 8'(bd);
    model_edge(av, aa, ad, bv, ba, bd, ga, gb);
    exp_rdy_q.push_back({ga, gb});
    e.o0 = 8'(m_reg[0]); e.o1 = 8'(m_reg[1]); e.o2 = 8'(m_reg[2]);
    e.o3 = 8'(m_reg[3]); e.o4 = 8'(m_reg[4]);
    e.busy = m_en && (m_reg[4] != m_reg[5]);
    e.err  = m_err;
    exp_state_q.push_back(e);
  endtask

  task automatic idle(input int n);
    bit ga, gb;
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, ga, gb);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_regs"}, 64'({r0, r1, r2, r3, r4}), 64'd0);
    check({tag, "_ready"}, 64'({a_ready, b_ready}), 64'd0);
    check({tag, "_flags"}, 64'({fade_busy, addr_err}), 64'd0);
  endtask

  // Monitor: post-edge register state at +1, combinational readies at +4.
  initial begin
    obs_t e, act;
    logic [1:0] r;
    forever begin
      @(posedge clk); #1;
      if (exp_state_q.size() > 0) begin
        e = exp_state_q.pop_front();
        act = {r0, r1, r2, r3, r4, fade_busy, addr_err};
        check("state", 64'(act), 64'(e));
      end
      #3;
      if (exp_rdy_q.size() > 0) begin
        r = exp_rdy_q.pop_front();
        check("ready", 64'({a_ready, b_ready}), 64'(r));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ga, gb;
    bit pa_v, pb_v;
    int unsigned pa_a, pa_d, pb_a, pb_d, na, nb;

    reset = 1'b1;
    a_valid = 1'b1; a_addr = '0; a_data = 8'h5A;
    b_valid = 1'b1; b_addr = '0; b_data = 8'hA5;
    model_reset();
    #1;
    check_reset_outputs("reset0");
    repeat (2) @(posedge clk);
    #2;
    a_valid = 1'b0; b_valid = 1'b0;
    reset = 1'b0;

    // 1: lone A write to duty
    cycle(1, 4, 8'h80, 0, 0, 0, ga, gb);
    idle(1);

    // 2: four writes per port under contention, holding until granted
    na = 0; nb = 0;
    while (na < 4 || nb < 4) begin
      cycle(na < 4, 0, 8'h11 + na, nb < 4, 1, 8'h22 + nb, ga, gb);
      if (ga) na++;
      if (gb) nb++;
    end

    // 3: unmapped host write
    cycle(0, 0, 0, 1, 8'h10, 8'h77, ga, gb);
    idle(2);

    // 4: fade up three steps, then retarget down by one
    cycle(1, 4, 8'h10, 0, 0, 0, ga, gb);
    cycle(1, 5, 8'h13, 0, 0, 0, ga, gb);
    cycle(1, 6, 8'h01, 0, 0, 0, ga, gb);
    idle(14);
    cycle(0, 0, 0, 1, 5, 8'h12, ga, gb);
    idle(6);

    // 5: duty write in the exact step cycle drops the step
    cycle(1, 5, 8'h20, 0, 0, 0, ga, gb);
    while ((m_cnt % FADE_DIV) != FADE_DIV - 1) idle(1);
    cycle(1, 4, 8'h50, 0, 0, 0, ga, gb);
    idle(FADE_DIV * 2 + 1);

    // 6: asynchronous reset mid-fade with A requesting
    cycle(1, 4, 8'h33, 0, 0, 0, ga, gb);
    #4;
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_mid");
    exp_state_q.delete();
    exp_rdy_q.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    a_valid = 1'b0; b_valid = 1'b0;
    reset = 1'b0;
    cycle(1, 2, 8'hC3, 1, 3, 8'h3C, ga, gb);
    cycle(0, 2, 8'hC3, 1, 3, 8'h3C, ga, gb);

    // Random traffic with held requests
    pa_v = 0; pb_v = 0; pa_a = 0; pa_d = 0; pb_a = 0; pb_d = 0;
    for (int i = 0; i < 400; i++) begin
      if (!pa_v && $urandom_range(0, 1) == 1) begin
        pa_v = 1; pa_a = $urandom_range(0, 9); pa_d = $urandom_range(0, 255);
      end
      if (!pb_v && $urandom_range(0, 2) == 0) begin
        pb_v = 1; pb_a = $urandom_range(0, 8); pb_d = $urandom_range(0, 255);
      end
      cycle(pa_v, pa_a, pa_d, pb_v, pb_a, pb_d, ga, gb);
      if (ga) pa_v = 0;
      if (gb) pb_v = 0;
    end
    idle(1);
    @(posedge clk); #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
